// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch and PC sequencing stage: fetches one word over a req/ready
// handshake, holds it for an issue window, then commits the selected next PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic [1:0]       PC_s,
  input  logic [31:0]      rs_data,
  input  logic             stall,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [5:0]       OP,
  output logic [5:0]       func,
  output logic [15:0]      imm16,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic [31:0]      next_pc_s;
  logic             unused_rs_lo_s;

  // Select 00 seq, 01 jr (word-aligned rs), 10 pc-relative branch, 11 region jump.
  function automatic logic [31:0] calc_next_pc(input logic [1:0]  sel,
                                               input logic [31:0] pc_v,
                                               input logic [31:0] ins,
                                               input logic [31:0] rs_v);
    logic [31:0] p4;
    p4 = pc_v + 32'd4;
    case (sel)
      2'b00:   return p4;
      2'b01:   return {rs_v[31:2], 2'b00};
      2'b10:   return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
      2'b11:   return {p4[31:28], ins[25:0], 2'b00};
      default: return p4;
    endcase
  endfunction

  assign next_pc_s      = calc_next_pc(PC_s, pc_q, instr_q, rs_data);
  assign unused_rs_lo_s = ^rs_data[1:0];

  // Next-state logic for the IDLE -> FETCH -> ISSUE sequence.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_d      = next_pc_s;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_ISSUE);
  end

  // State and output registers; reset drops the request without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign OP          = instr_q[31:26];
  assign func        = instr_q[5:0];
  assign imm16       = instr_q[15:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed program with hand-computed
// fetch addresses and issue records, plus stall, wait-state and async-reset checks.
module tb_instr_fetch_unit;

  localparam int CNT_W = 3;

  logic             clk, rst_n;
  logic             imem_req, imem_ready;
  logic [31:0]      imem_addr, imem_rdata, rs_data;
  logic [1:0]       PC_s;
  logic             stall, instr_valid;
  logic [31:0]      instr, pc, pc_plus4;
  logic [5:0]       OP, func;
  logic [15:0]      imm16;
  logic [CNT_W-1:0] retired;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_s(PC_s),
    .rs_data(rs_data), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .OP(OP), .func(func), .imm16(imm16), .pc(pc),
    .pc_plus4(pc_plus4), .retired(retired)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  pcs;
    logic [31:0] rs;
    int          waits;
    int          stalls;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [31:0] ret;
  } iss_t;

  vec_t        vecs[13];
  logic [31:0] addr_q[$];
  iss_t        iss_q[$];
  int          n_vec = 0;
  int          n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                              input logic [31:0] r, input int w, input int st, input logic [31:0] rt);
    vec_t v;
    v.addr = a; v.rdata = d; v.pcs = s; v.rs = r; v.waits = w; v.stalls = st; v.ret = rt;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t        v;
    iss_t        e;
    logic [31:0] held;
    v = vecs[i];
    e.ins = v.rdata; e.pcv = v.addr; e.ret = v.ret;
    addr_q.push_back(v.addr);
    iss_q.push_back(e);
    for (int k = 0; k < 20 && !imem_req; k++) tick;
    chk("req_seen", 32'(imem_req), 32'd1);
    held = imem_addr;
    for (int w = 0; w < v.waits; w++) begin
      tick;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr_stable", imem_addr, held);
      chk("wait_valid_low", 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = v.rdata;
    tick;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int s = 0; s < v.stalls; s++) begin
      stall = 1'b1;
      tick;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc", pc, v.addr);
      chk("stall_retired", 32'(retired), v.ret);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_instr", instr, v.rdata);
    end
    stall   = 1'b0;
    PC_s    = v.pcs;
    rs_data = v.rs;
    tick;
    PC_s    = 2'b01;
    rs_data = 32'h5A5A_5A5A;
  endtask

  // Monitor: check each accepted fetch address and each new issue window.
  initial begin : monitor
    logic prev_valid;
    iss_t e;
    logic [31:0] a;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (imem_req && imem_ready) begin
          if (addr_q.size() == 0) chk("fetch_unexpected", imem_addr, 32'hFFFF_FFFF);
          else begin
            a = addr_q.pop_front();
            chk("fetch_addr", imem_addr, a);
          end
        end
        if (instr_valid && !prev_valid) begin
          if (iss_q.size() == 0) chk("issue_unexpected", instr, 32'hFFFF_FFFF);
          else begin
            e = iss_q.pop_front();
            chk("issue_instr", instr, e.ins);
            chk("issue_OP", 32'(OP), 32'(e.ins[31:26]));
            chk("issue_func", 32'(func), 32'(e.ins[5:0]));
            chk("issue_imm16", 32'(imm16), 32'(e.ins[15:0]));
            chk("issue_pc", pc, e.pcv);
            chk("issue_pc_plus4", pc_plus4, e.pcv + 32'd4);
            chk("issue_retired", 32'(retired), e.ret);
            chk("issue_req_low", 32'(imem_req), 32'd0);
          end
        end
        prev_valid = instr_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    vecs[0]  = mk(32'h0000_0000, 32'h012A_4020, 2'b00, 32'h0,         0, 0, 32'd0);
    vecs[1]  = mk(32'h0000_0004, 32'h8C22_0008, 2'b00, 32'h0,         3, 0, 32'd1);
    vecs[2]  = mk(32'h0000_0008, 32'h0060_0008, 2'b01, 32'h0000_1237, 0, 5, 32'd2);
    vecs[3]  = mk(32'h0000_1234, 32'h0080_0008, 2'b01, 32'h0000_0010, 1, 0, 32'd3);
    vecs[4]  = mk(32'h0000_0010, 32'h1000_FFFE, 2'b10, 32'h0,         0, 0, 32'd4);
    vecs[5]  = mk(32'h0000_000C, 32'h0000_0000, 2'b00, 32'h0,         0, 0, 32'd5);
    vecs[6]  = mk(32'h0000_0010, 32'h1000_0003, 2'b10, 32'h0,         0, 1, 32'd6);
    vecs[7]  = mk(32'h0000_0020, 32'h03E0_0008, 2'b01, 32'h4000_0002, 0, 0, 32'd7);
    vecs[8]  = mk(32'h4000_0000, 32'h0800_0100, 2'b11, 32'h0,         2, 0, 32'd0);
    vecs[9]  = mk(32'h4000_0400, 32'h0120_0008, 2'b01, 32'hFFFF_FFFF, 0, 0, 32'd1);
    vecs[10] = mk(32'hFFFF_FFFC, 32'h2108_0001, 2'b00, 32'h0,         0, 0, 32'd2);
    vecs[11] = mk(32'h0000_0000, 32'h0140_0008, 2'b01, 32'h0000_0100, 0, 0, 32'd3);
    vecs[12] = mk(32'h0000_0000, 32'h3C01_1234, 2'b00, 32'h0,         0, 0, 32'd0);

    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; PC_s = 2'b00;
    rs_data = 32'h0; stall = 1'b0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", instr, 32'h0);
    #11;
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    tick;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Fetch of 0x100 is pending; reset between edges must abort it at once.
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h0000_0100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_retired", 32'(retired), 32'd0);
    tick;
    tick;
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle_req", 32'(imem_req), 32'd0);
    tick;
    chk("post_rst_fetch_req", 32'(imem_req), 32'd1);
    chk("post_rst_fetch_addr", imem_addr, 32'h0);

    run_vec(12);
    chk("final_retired", 32'(retired), 32'd1);
    chk("final_addr", imem_addr, 32'h0000_0004);
    repeat (3) tick;
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
